// File: rtl/result_screen_ctrl_pkg.sv
// Shared definitions for the end-of-game result screen sequencer:
// result codes, sequencer states and grant bit positions.
package result_screen_ctrl_pkg;

  localparam logic [1:0] RES_NONE  = 2'b00;
  localparam logic [1:0] RES_X_WIN = 2'b01;
  localparam logic [1:0] RES_O_WIN = 2'b10;
  localparam logic [1:0] RES_DRAW  = 2'b11;

  localparam int unsigned GNT_PVP = 0;
  localparam int unsigned GNT_AI  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ANIMATE,
    ST_HOLD,
    ST_ACK,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/result_screen_ctrl_frame_tick_gen.sv
// Free-running animation frame strobe: a one-cycle clock-enable pulse
// every CLOCK_SPEED/FRAME_RATE cycles.
module frame_tick_gen #(
  parameter int unsigned CLOCK_SPEED = 100_000_000,
  parameter int unsigned FRAME_RATE  = 6
) (
  input  logic clk,
  input  logic reset,
  output logic frame_tick
);

  localparam int unsigned RATE   = (FRAME_RATE == 0) ? 1 : FRAME_RATE;
  localparam int unsigned PERIOD = (CLOCK_SPEED / RATE == 0) ? 1 : CLOCK_SPEED / RATE;
  localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == LAST);
    cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/result_screen_ctrl.sv
// Result screen sequencer: arbitrates PvP/AI result requests and drives the
// shared animation engine. Optional macro: RESULT_ANIM_TIMEOUT_EN.
module result_screen_ctrl
  import result_screen_ctrl_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED         = 100_000_000,
  parameter int unsigned FRAME_RATE          = 6,
  parameter int unsigned HOLD_FRAMES         = 12,
  parameter int unsigned ANIM_TIMEOUT_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_pvp,
  input  logic [1:0] req_ai,
  input  logic       anim_done,
  output logic       frame_tick,
  output logic       anim_start,
  output logic [1:0] anim_sel,
  output logic       show_result,
  output logic [1:0] grant,
  output logic       ack_pvp,
  output logic       ack_ai,
  output logic       busy
);

  localparam int unsigned HOLD_EFF = (HOLD_FRAMES == 0) ? 1 : HOLD_FRAMES;
  localparam int unsigned TO_EFF   = (ANIM_TIMEOUT_FRAMES == 0) ? 1 : ANIM_TIMEOUT_FRAMES;
  localparam int unsigned FMAX     = (HOLD_EFF > TO_EFF) ? HOLD_EFF : TO_EFF;
  localparam int unsigned FCNT_W   = $clog2(FMAX + 1);
  localparam logic [FCNT_W-1:0] HOLD_LAST = FCNT_W'(HOLD_EFF - 1);
`ifdef RESULT_ANIM_TIMEOUT_EN
  localparam logic [FCNT_W-1:0] TO_LAST = FCNT_W'(TO_EFF - 1);
`endif

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        sel_q, sel_d;
  logic              last_ai_q, last_ai_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              anim_start_q, anim_start_d;
  logic              show_q, show_d;
  logic              ack_pvp_q, ack_pvp_d;
  logic              ack_ai_q, ack_ai_d;
  logic              busy_q, busy_d;
  logic [1:0]        gnt_req;

  frame_tick_gen #(
    .CLOCK_SPEED(CLOCK_SPEED),
    .FRAME_RATE (FRAME_RATE)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      sel_q        <= RES_NONE;
      last_ai_q    <= 1'b1;
      fcnt_q       <= '0;
      anim_start_q <= 1'b0;
      show_q       <= 1'b0;
      ack_pvp_q    <= 1'b0;
      ack_ai_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      sel_q        <= sel_d;
      last_ai_q    <= last_ai_d;
      fcnt_q       <= fcnt_d;
      anim_start_q <= anim_start_d;
      show_q       <= show_d;
      ack_pvp_q    <= ack_pvp_d;
      ack_ai_q     <= ack_ai_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    last_ai_d = last_ai_q;
    fcnt_d    = fcnt_q;
    gnt_req   = grant_q[GNT_PVP] ? req_pvp : req_ai;
    case (state_q)
      ST_IDLE: begin
        // On a tie, the requester not served last time wins.
        if ((req_pvp != RES_NONE) && ((req_ai == RES_NONE) || last_ai_q)) begin
          grant_d          = '0;
          grant_d[GNT_PVP] = 1'b1;
          sel_d            = req_pvp;
          last_ai_d        = 1'b0;
          fcnt_d           = '0;
          state_d          = ST_ANIMATE;
        end else if (req_ai != RES_NONE) begin
          grant_d         = '0;
          grant_d[GNT_AI] = 1'b1;
          sel_d           = req_ai;
          last_ai_d       = 1'b1;
          fcnt_d          = '0;
          state_d         = ST_ANIMATE;
        end
      end
      ST_ANIMATE: begin
        if (gnt_req == RES_NONE) begin
          state_d = ST_IDLE;
        end else if (anim_done) begin
          state_d = ST_HOLD;
          fcnt_d  = '0;
        end
`ifdef RESULT_ANIM_TIMEOUT_EN
        else if (frame_tick) begin
          if (fcnt_q == TO_LAST) begin
            state_d = ST_HOLD;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
        end
`endif
      end
      ST_HOLD: begin
        if (gnt_req == RES_NONE) begin
          state_d = ST_IDLE;
        end else if (frame_tick) begin
          if (fcnt_q == HOLD_LAST) state_d = ST_ACK;
          else                     fcnt_d  = fcnt_q + FCNT_W'(1);
        end
      end
      ST_ACK:     state_d = ST_RELEASE;
      ST_RELEASE: if (gnt_req == RES_NONE) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) begin
      grant_d = '0;
      sel_d   = RES_NONE;
    end
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    busy_d       = (state_d != ST_IDLE);
    anim_start_d = (state_d != ST_IDLE);
    show_d       = (state_d inside {ST_HOLD, ST_ACK, ST_RELEASE});
    ack_pvp_d    = (state_d == ST_ACK) && grant_d[GNT_PVP];
    ack_ai_d     = (state_d == ST_ACK) && grant_d[GNT_AI];
  end

  assign anim_start  = anim_start_q;
  assign anim_sel    = sel_q;
  assign show_result = show_q;
  assign grant       = grant_q;
  assign ack_pvp     = ack_pvp_q;
  assign ack_ai      = ack_ai_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_result_screen_ctrl.sv
// Self-checking bench for result_screen_ctrl: directed vector table,
// reset/tick sequences and randomized traffic against a reference model.
module tb_result_screen_ctrl;
  import result_screen_ctrl_pkg::*;

  localparam int unsigned CS = 60, FR = 6, HF = 3, TO = 4;
  localparam int unsigned PERIOD = CS / FR;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_pvp, req_ai;
  logic       anim_done;
  logic       frame_tick, anim_start, show_result, ack_pvp, ack_ai, busy;
  logic [1:0] anim_sel, grant;

  result_screen_ctrl #(
    .CLOCK_SPEED        (CS),
    .FRAME_RATE         (FR),
    .HOLD_FRAMES        (HF),
    .ANIM_TIMEOUT_FRAMES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_pvp    (req_pvp),
    .req_ai     (req_ai),
    .anim_done  (anim_done),
    .frame_tick (frame_tick),
    .anim_start (anim_start),
    .anim_sel   (anim_sel),
    .show_result(show_result),
    .grant      (grant),
    .ack_pvp    (ack_pvp),
    .ack_ai     (ack_ai),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which requester owns the screen and how far along it is.
  int         m_owner;   // 0 none, 1 PvP, 2 AI
  int         m_last;
  int         m_ticks;
  int         m_cyc;
  logic [1:0] m_sel;
  bit         m_over, m_acked, m_ackp, m_acka, m_tick;

  typedef struct {
    bit          rst;
    logic [1:0]  rp;
    logic [1:0]  ra;
    logic        ad;
    int unsigned n;
    logic [8:0]  exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [8:0] ex(input logic b, input logic s, input logic [1:0] g,
                                    input logic [1:0] a, input logic kp, input logic ka);
    return {b, b, s, g, a, kp, ka};
  endfunction

  function automatic logic [8:0] outs_now();
    return {busy, anim_start, show_result, grant, anim_sel, ack_pvp, ack_ai};
  endfunction

  function automatic logic [8:0] model_outs();
    logic [1:0] g;
    g = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    return ex(m_owner != 0, (m_owner != 0) && m_over, g,
              (m_owner != 0) ? m_sel : 2'b00, m_ackp, m_acka);
  endfunction

  function automatic void add(input bit rst, input logic [1:0] rp, input logic [1:0] ra,
                              input logic ad, input int unsigned n, input logic [8:0] e);
    vec_t v;
    v.rst = rst; v.rp = rp; v.ra = ra; v.ad = ad; v.n = n; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic chk9(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {busy,start,show,grant,sel,ackp,acka}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_owner = 0; m_last = 2; m_ticks = 0; m_cyc = 0; m_sel = 2'b00;
    m_over = 0; m_acked = 0; m_ackp = 0; m_acka = 0; m_tick = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_pvp = 2'b00; req_ai = 2'b00; anim_done = 1'b0;
    step();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic model_step(input bit rst, input logic [1:0] rp, input logic [1:0] ra,
                            input logic ad);
    bit         tick_in, in_ack;
    logic [1:0] r;
    if (rst) begin
      model_reset();
      return;
    end
    tick_in = m_tick;
    in_ack  = m_ackp | m_acka;
    m_cyc++;
    m_tick = (m_cyc % PERIOD == 0);
    m_ackp = 0; m_acka = 0;
    if (m_owner == 0) begin
      if (rp != 0 && (ra == 0 || m_last == 2)) begin m_owner = 1; m_sel = rp; end
      else if (ra != 0)                         begin m_owner = 2; m_sel = ra; end
      if (m_owner != 0) begin
        m_last = m_owner; m_over = 0; m_ticks = 0; m_acked = 0;
      end
    end else begin
      r = (m_owner == 1) ? rp : ra;
      if (!m_acked) begin
        if (r == 0) m_owner = 0;
        else if (!m_over) begin
          if (ad) begin m_over = 1; m_ticks = 0; end
`ifdef RESULT_ANIM_TIMEOUT_EN
          else if (tick_in) begin
            m_ticks++;
            if (m_ticks == TO) begin m_over = 1; m_ticks = 0; end
          end
`endif
        end else if (tick_in) begin
          m_ticks++;
          if (m_ticks == HF) begin
            m_acked = 1;
            if (m_owner == 1) m_ackp = 1; else m_acka = 1;
          end
        end
      end else if (!in_ack && r == 0) begin
        m_owner = 0;
      end
    end
  endtask

  initial begin
    logic [8:0] z;
    bit         done_p, done_a, rnd_rst;
    z = ex(0, 0, 2'b00, 2'b00, 0, 0);

    // Reset state and free-running tick cadence.
    do_reset();
    chk9("reset_outputs", outs_now(), z);
    chk1("reset_tick", frame_tick, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      step();
      chk1($sformatf("tick_edge%0d", k), frame_tick, (k % 10) == 0);
      if (k % 10 == 0) chk9($sformatf("idle_edge%0d", k), outs_now(), z);
    end

    // PvP X win; code change during hold is ignored.
    add(1, RES_X_WIN, RES_NONE, 0, 1,  ex(1, 0, 2'b01, RES_X_WIN, 0, 0));
    add(0, RES_X_WIN, RES_NONE, 0, 24, ex(1, 0, 2'b01, RES_X_WIN, 0, 0));
    add(0, RES_X_WIN, RES_NONE, 1, 1,  ex(1, 1, 2'b01, RES_X_WIN, 0, 0));
    add(0, RES_DRAW,  RES_NONE, 1, 24, ex(1, 1, 2'b01, RES_X_WIN, 0, 0));
    add(0, RES_DRAW,  RES_NONE, 1, 1,  ex(1, 1, 2'b01, RES_X_WIN, 1, 0));
    add(0, RES_DRAW,  RES_NONE, 1, 1,  ex(1, 1, 2'b01, RES_X_WIN, 0, 0));
    add(0, RES_NONE,  RES_NONE, 0, 1,  z);
    // Tie after reset: PvP first, then AI, then PvP again.
    add(1, RES_O_WIN, RES_DRAW, 1, 1,  ex(1, 0, 2'b01, RES_O_WIN, 0, 0));
    add(0, RES_O_WIN, RES_DRAW, 1, 1,  ex(1, 1, 2'b01, RES_O_WIN, 0, 0));
    add(0, RES_O_WIN, RES_DRAW, 1, 28, ex(1, 1, 2'b01, RES_O_WIN, 0, 0));
    add(0, RES_O_WIN, RES_DRAW, 1, 1,  ex(1, 1, 2'b01, RES_O_WIN, 1, 0));
    add(0, RES_NONE,  RES_DRAW, 1, 1,  ex(1, 1, 2'b01, RES_O_WIN, 0, 0));
    add(0, RES_NONE,  RES_DRAW, 1, 1,  z);
    add(0, RES_NONE,  RES_DRAW, 1, 1,  ex(1, 0, 2'b10, RES_DRAW, 0, 0));
    add(0, RES_NONE,  RES_DRAW, 1, 1,  ex(1, 1, 2'b10, RES_DRAW, 0, 0));
    add(0, RES_NONE,  RES_DRAW, 1, 25, ex(1, 1, 2'b10, RES_DRAW, 0, 0));
    add(0, RES_NONE,  RES_DRAW, 1, 1,  ex(1, 1, 2'b10, RES_DRAW, 0, 1));
    add(0, RES_NONE,  RES_NONE, 1, 1,  ex(1, 1, 2'b10, RES_DRAW, 0, 0));
    add(0, RES_NONE,  RES_NONE, 1, 1,  z);
    add(0, RES_X_WIN, RES_X_WIN, 1, 1, ex(1, 0, 2'b01, RES_X_WIN, 0, 0));
    // AI abort during hold: no ack.
    add(1, RES_NONE, RES_DRAW, 1, 1,  ex(1, 0, 2'b10, RES_DRAW, 0, 0));
    add(0, RES_NONE, RES_DRAW, 1, 1,  ex(1, 1, 2'b10, RES_DRAW, 0, 0));
    add(0, RES_NONE, RES_NONE, 1, 1,  z);
    add(0, RES_NONE, RES_NONE, 1, 20, z);
`ifdef RESULT_ANIM_TIMEOUT_EN
    add(1, RES_NONE, RES_X_WIN, 0, 1,  ex(1, 0, 2'b10, RES_X_WIN, 0, 0));
    add(0, RES_NONE, RES_X_WIN, 0, 39, ex(1, 0, 2'b10, RES_X_WIN, 0, 0));
    add(0, RES_NONE, RES_X_WIN, 0, 1,  ex(1, 1, 2'b10, RES_X_WIN, 0, 0));
    add(0, RES_NONE, RES_X_WIN, 0, 29, ex(1, 1, 2'b10, RES_X_WIN, 0, 0));
    add(0, RES_NONE, RES_X_WIN, 0, 1,  ex(1, 1, 2'b10, RES_X_WIN, 0, 1));
    add(0, RES_NONE, RES_NONE,  0, 1,  ex(1, 1, 2'b10, RES_X_WIN, 0, 0));
    add(0, RES_NONE, RES_NONE,  0, 1,  z);
`else
    add(1, RES_NONE, RES_X_WIN, 0, 1,  ex(1, 0, 2'b10, RES_X_WIN, 0, 0));
    add(0, RES_NONE, RES_X_WIN, 0, 79, ex(1, 0, 2'b10, RES_X_WIN, 0, 0));
    add(0, RES_NONE, RES_NONE,  0, 1,  z);
`endif

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      req_pvp = tbl[i].rp; req_ai = tbl[i].ra; anim_done = tbl[i].ad;
      repeat (tbl[i].n) step();
      chk9($sformatf("vec%0d", i), outs_now(), tbl[i].exp);
    end

    // Reset during ANIMATE clears outputs and restarts the tick counter.
    do_reset();
    req_pvp = RES_O_WIN;
    repeat (5) step();
    chk9("pre_reset_anim", outs_now(), ex(1, 0, 2'b01, RES_O_WIN, 0, 0));
    reset = 1'b1;
    step();
    chk9("midreset_outputs", outs_now(), z);
    reset = 1'b0; req_pvp = RES_NONE;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk1($sformatf("midreset_tick%0d", k), frame_tick, k == 10);
    end

    // Randomized traffic against the reference model.
    do_reset();
    done_p = 0; done_a = 0;
    for (int c = 0; c < 4000; c++) begin
      if (req_pvp == 0) begin
        done_p = 0;
        if ($urandom_range(0, 15) == 0) req_pvp = 2'($urandom_range(1, 3));
      end else if (done_p) begin
        if ($urandom_range(0, 2) == 0) req_pvp = 2'b00;
      end else if ($urandom_range(0, 149) == 0) req_pvp = 2'b00;
      else if ($urandom_range(0, 99) == 0) req_pvp = 2'($urandom_range(1, 3));
      if (req_ai == 0) begin
        done_a = 0;
        if ($urandom_range(0, 15) == 0) req_ai = 2'($urandom_range(1, 3));
      end else if (done_a) begin
        if ($urandom_range(0, 2) == 0) req_ai = 2'b00;
      end else if ($urandom_range(0, 149) == 0) req_ai = 2'b00;
      else if ($urandom_range(0, 99) == 0) req_ai = 2'($urandom_range(1, 3));
      anim_done = ($urandom_range(0, 9) == 0);
      rnd_rst   = ($urandom_range(0, 799) == 0);
      reset     = rnd_rst;
      step();
      model_step(rnd_rst, req_pvp, req_ai, anim_done);
      chk9($sformatf("rand%0d", c), outs_now(), model_outs());
      chk1($sformatf("rand_tick%0d", c), frame_tick, m_tick);
      if (m_ackp) done_p = 1;
      if (m_acka) done_a = 1;
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/result_screen_ctrl.md
Name: result_screen_ctrl

Overview:
Sequences the shared end-of-game animation/result-screen engine on the OLED: X-win, O-win and draw animations plus the static result overlay.
- Arbitrates between two result requesters: the PvP game core and the AI game core.
- Generates the animation frame tick, latches the winning result, and drives the engine's start/select.
- Times the result-hold phase, then acknowledges the granted requester.

Parameters:
CLOCK_SPEED, 100_000_000, system clock frequency in Hz
FRAME_RATE, 6, animation frames per second; tick period = CLOCK_SPEED/FRAME_RATE cycles
HOLD_FRAMES, 12, frame ticks the result overlay is held after the animation completes
ANIM_TIMEOUT_FRAMES, 64, frame ticks allowed for anim_done before forced advance (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_pvp  in  2  PvP result: 00 none, 01 X win, 10 O win, 11 draw (level, held until ack)
req_ai  in  2  AI result, same encoding
anim_done  in  1  engine: current animation finished (level)
frame_tick  out  1  one-cycle pulse every CLOCK_SPEED/FRAME_RATE cycles, free-running
anim_start  out  1  engine start level; low resets the engine
anim_sel  out  2  latched result code selecting the animation/overlay
show_result  out  1  result overlay enable
grant  out  2  one-hot: bit0 PvP, bit1 AI; 00 when idle
ack_pvp  out  1  one-cycle pulse: PvP sequence complete
ack_ai  out  1  one-cycle pulse: AI sequence complete
busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. Reset values: every output 0; state IDLE; tick counter 0; frame counter 0; last_grant = AI, so PvP wins the first tie.
- frame_tick: counter runs 0..CLOCK_SPEED/FRAME_RATE-1 and pulses at the terminal count. The counter width comes from $clog2. The tick is not restarted per state, so the first counted frame may be partial.
- IDLE:
  - One nonzero request -> grant it.
  - Both nonzero in the same cycle -> grant the one != last_grant.
  - On grant: latch the code into anim_sel, set grant, update last_grant, anim_start=1, go to ANIMATE. Outputs change on the edge after the request is first sampled (latency 1 cycle).
- ANIMATE: anim_start=1. On anim_done=1 -> HOLD with frame counter cleared and show_result=1.
- HOLD: anim_start=1, show_result=1. Count frame ticks; at the HOLD_FRAMES-th tick -> ACK.
- ACK: one cycle. Pulse ack_pvp or ack_ai per grant; anim_start and show_result stay 1. Go to RELEASE.
- RELEASE: hold the screen until the granted request reads 00, then go to IDLE the next cycle and clear anim_start, show_result, grant and anim_sel.
- The granted request changing to a different nonzero code mid-sequence is ignored; the latched anim_sel is used.
- Abort: if the granted request drops to 00 in ANIMATE or HOLD, go to IDLE next cycle, clear outputs, no ack.
- The non-granted requester waits. It is serviced from IDLE after release and is never preempted.
- HOLD_FRAMES=0 is treated as 1.
- Reset mid-operation returns everything to reset values on the next edge.

Optional Feature:
RESULT_ANIM_TIMEOUT_EN
- Defined: in ANIMATE, frame ticks are counted. At the ANIM_TIMEOUT_FRAMES-th tick without anim_done, advance to HOLD exactly as if anim_done had arrived.
- Undefined: ANIMATE waits for anim_done indefinitely; the timeout counter and parameter are unused.

Decomposition:
- Shared package: result code localparams (RES_NONE=00, RES_X_WIN=01, RES_O_WIN=10, RES_DRAW=11), state encoding (IDLE, ANIMATE, HOLD, ACK, RELEASE), and the grant bit indices.
- One natural sub-module: frame_tick_gen (CLOCK_SPEED, FRAME_RATE; clk, reset -> frame_tick). It replaces toggle-clock derivation with a clock-enable pulse.

Test Plan:
- Simulation parameters: CLOCK_SPEED=60, FRAME_RATE=6 (tick every 10 cycles), HOLD_FRAMES=3.
- After reset, frame_tick pulses at cycles 10, 20, 30; all other outputs 0.
- req_pvp=01, anim_done asserted 25 cycles later -> grant=01 and anim_sel=01 one cycle after the request; show_result rises with HOLD; ack_pvp pulses once after 3 ticks; clearing req_pvp returns to IDLE next cycle.
- req_pvp=10 and req_ai=11 in the same cycle after reset -> PvP granted first. After PvP is acked and cleared, AI is granted with anim_sel=11. A repeated tie then goes to PvP, since last_grant=AI.
- req_ai=11 dropped to 00 during HOLD -> IDLE next cycle, no ack_ai, all outputs 0.
- With RESULT_ANIM_TIMEOUT_EN and ANIM_TIMEOUT_FRAMES=4, req_ai=01 with anim_done held low -> HOLD entered on the 4th tick, then ack_ai after 3 more ticks.
- reset asserted during ANIMATE -> next cycle anim_start=0, grant=00, busy=0, tick counter restarted at 0.
